// File: rtl/sensor_report_tx.sv
// sensor_report_tx
// Takes a snapshot of N_CH unsigned sensor readings when triggered. Each valid
// reading is converted to DIGITS decimal digits by sequential double-dabble,
// and the frame is streamed as ASCII bytes through a byte transmitter:
//   d..d,d..d,...,d..d CR LF
// A reading too large for DIGITS digits is sent as all '9'. An invalid channel
// is sent as DIGITS dashes.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   frame_req    one-cycle request for a report frame
//   ch_data      packed readings, channel k at [k*DATA_W +: DATA_W]
//   ch_valid     per-channel valid flags
//   tx_busy      byte transmitter busy
//   tx_start     one-cycle pulse launching tx_data
//   tx_data      ASCII byte, held until the next tx_start
//   frame_busy   high from frame acceptance until frame_done
//   frame_done   one-cycle pulse when the frame is complete
//   req_dropped  one-cycle pulse for a trigger that arrives while a frame runs
module sensor_report_tx #(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 8,
  parameter int DIGITS      = 3,
  parameter int AUTO_PERIOD = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_req,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic                     req_dropped
);

  localparam int BW   = 4 * DIGITS;
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW   = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam int MAXV = 10 ** DIGITS - 1;

  localparam logic [TW-1:0] T_LAST   = TW'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);
  localparam logic [CW-1:0] CH_LAST  = CW'(N_CH - 1);
  localparam logic [2:0]    DIG_LAST = 3'(DIGITS - 1);
  localparam logic [4:0]    BIT_LAST = 5'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, CONV, EMIT, WAIT, SEP, CR, LF, DONE} state_t;
  // Remembers what was just handed to the transmitter so WAIT knows where to go.
  typedef enum logic [1:0] {K_DIG, K_SEP, K_CR, K_LF} kind_t;

  state_t                   state;
  kind_t                    kind;
  logic [N_CH*DATA_W-1:0]   snap_data;
  logic [N_CH-1:0]          snap_valid;
  logic [CW-1:0]            ch_idx;
  logic [DATA_W-1:0]        bin;
  logic [BW-1:0]            bcd;
  logic [4:0]               bit_cnt;
  logic [2:0]               dig_idx;
  logic                     sat;
  logic                     dash;
  logic [TW-1:0]            timer;

  logic                     auto_fire;
  logic                     trigger;
  logic                     wait_exit;
  logic                     load_ch;
  logic [CW-1:0]            nxt_idx;
  logic [DATA_W-1:0]        nxt_val;
  logic                     nxt_vld;
  logic [7:0]               emit_byte;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the
  // next binary bit. Digits above DIGITS are dropped; that only happens for
  // readings that saturate, whose BCD result is never used.
  function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] b, input logic in_bit);
    logic [BW-1:0] a;
    a = b;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5) a[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
    return {a[BW-2:0], in_bit};
  endfunction

  function automatic logic saturates(input logic [DATA_W-1:0] v);
    return 32'(v) > 32'(MAXV);
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 | {4'h0, d};
  endfunction

  assign auto_fire = (AUTO_PERIOD > 0) && (timer == T_LAST);
  assign trigger   = frame_req | auto_fire;
  // The tx_start cycle itself is skipped, because the transmitter may raise
  // busy only one cycle later.
  assign wait_exit = (state == WAIT) && !tx_start && !tx_busy;
  assign load_ch   = ((state == IDLE) && trigger) || (wait_exit && (kind == K_SEP));

  // Selects the channel that is about to start. At frame start the live
  // inputs are used, because the snapshot is written in the same cycle.
  always_comb begin
    nxt_idx = (state == IDLE) ? '0 : ch_idx + 1'b1;
    nxt_val = (state == IDLE) ? ch_data[DATA_W-1:0] : snap_data[int'(nxt_idx)*DATA_W +: DATA_W];
    nxt_vld = (state == IDLE) ? ch_valid[0] : snap_valid[nxt_idx];
  end

  always_comb begin
    if (dash)     emit_byte = 8'h2D;
    else if (sat) emit_byte = 8'h39;
    else          emit_byte = ascii_digit(bcd[BW-1 -: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (AUTO_PERIOD > 0) begin
      timer <= auto_fire ? '0 : timer + 1'b1;
    end
  end

  // Snapshot and conversion datapath. These registers have no reset; the FSM
  // loads them before it reads them.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && trigger) begin
      snap_data  <= ch_data;
      snap_valid <= ch_valid;
    end
    if (load_ch) begin
      bin <= nxt_val;
      bcd <= '0;
    end else if (state == CONV) begin
      bcd <= dabble_step(bcd, bin[DATA_W-1]);
      bin <= bin << 1;
    end else if ((state == EMIT) && !tx_busy) begin
      bcd <= bcd << 4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      kind        <= K_DIG;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      req_dropped <= 1'b0;
      ch_idx      <= '0;
      dig_idx     <= '0;
      bit_cnt     <= '0;
      sat         <= 1'b0;
      dash        <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
      req_dropped <= trigger && (state != IDLE);
      case (state)
        IDLE: begin
          if (trigger) begin
            frame_busy <= 1'b1;
            ch_idx     <= nxt_idx;
            dig_idx    <= '0;
            bit_cnt    <= '0;
            sat        <= saturates(nxt_val);
            dash       <= !nxt_vld;
            state      <= nxt_vld ? CONV : EMIT;
          end
        end
        CONV: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            state   <= EMIT;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= emit_byte;
            kind     <= K_DIG;
            state    <= WAIT;
          end
        end
        SEP: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= 8'h2C;
            kind     <= K_SEP;
            state    <= WAIT;
          end
        end
        CR: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= 8'h0D;
            kind     <= K_CR;
            state    <= WAIT;
          end
        end
        LF: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= 8'h0A;
            kind     <= K_LF;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_exit) begin
            case (kind)
              K_DIG: begin
                if (dig_idx == DIG_LAST) begin
                  dig_idx <= '0;
                  state   <= (ch_idx == CH_LAST) ? CR : SEP;
                end else begin
                  dig_idx <= dig_idx + 1'b1;
                  state   <= EMIT;
                end
              end
              K_SEP: begin
                ch_idx  <= nxt_idx;
                bit_cnt <= '0;
                sat     <= saturates(nxt_val);
                dash    <= !nxt_vld;
                state   <= nxt_vld ? CONV : EMIT;
              end
              K_CR: state <= LF;
              K_LF: begin
                state      <= DONE;
                frame_done <= 1'b1;
                frame_busy <= 1'b0;
              end
            endcase
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_report_tx.sv
// Bench for sensor_report_tx. Instance a uses DIGITS=3, instance b uses
// DIGITS=2, and instance c uses DIGITS=3 with AUTO_PERIOD=5000. A small
// transmitter model drives tx_busy for each instance. Expected frames are
// built from the readings with decimal arithmetic.
module tb_sensor_report_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [2:0]       req;
  logic [2:0][15:0] dat;
  logic [2:0][1:0]  vld;
  logic [2:0]       stall;
  logic [2:0][2:0]  blen;
  logic [2:0][2:0]  bcnt = '0;
  logic [2:0]       busy;
  logic [2:0]       st, fb, fd, dr;
  logic [2:0][7:0]  td;
  logic [2:0][7:0]  lastb = '0;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt[3] = '{0, 0, 0};
  int done_cnt[3]  = '{0, 0, 0};
  int drop_cnt[3]  = '{0, 0, 0};
  int viol_cnt[3]  = '{0, 0, 0};
  logic [7:0] cap0[$], cap1[$], cap2[$], got_q[$], exp_q[$];

  sensor_report_tx #(.N_CH(2), .DATA_W(8), .DIGITS(3), .AUTO_PERIOD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_req(req[0]), .ch_data(dat[0]), .ch_valid(vld[0]),
    .tx_busy(busy[0]), .tx_start(st[0]), .tx_data(td[0]), .frame_busy(fb[0]),
    .frame_done(fd[0]), .req_dropped(dr[0]));

  sensor_report_tx #(.N_CH(2), .DATA_W(8), .DIGITS(2), .AUTO_PERIOD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_req(req[1]), .ch_data(dat[1]), .ch_valid(vld[1]),
    .tx_busy(busy[1]), .tx_start(st[1]), .tx_data(td[1]), .frame_busy(fb[1]),
    .frame_done(fd[1]), .req_dropped(dr[1]));

  sensor_report_tx #(.N_CH(2), .DATA_W(8), .DIGITS(3), .AUTO_PERIOD(5000)) dut_c (
    .clk(clk), .rst_n(rst_n), .frame_req(req[2]), .ch_data(dat[2]), .ch_valid(vld[2]),
    .tx_busy(busy[2]), .tx_start(st[2]), .tx_data(td[2]), .frame_busy(fb[2]),
    .frame_done(fd[2]), .req_dropped(dr[2]));

  // Transmitter model: busy rises the cycle after tx_start and stays high
  // for blen cycles. stall forces busy high.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (st[i]) bcnt[i] <= blen[i];
      else if (bcnt[i] != 0) bcnt[i] <= bcnt[i] - 3'd1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < 3; i++) busy[i] = (bcnt[i] != 0) | stall[i];
  end

  // Byte capture and protocol watch on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        lastb[i] = 8'h00;
      end else begin
        if (st[i]) begin
          start_cnt[i]++;
          if (busy[i]) viol_cnt[i]++;
          lastb[i] = td[i];
          case (i)
            0: cap0.push_back(td[i]);
            1: cap1.push_back(td[i]);
            default: cap2.push_back(td[i]);
          endcase
        end else if (busy[i] && (td[i] !== lastb[i])) begin
          viol_cnt[i]++;
        end
        if (fd[i]) done_cnt[i]++;
        if (dr[i]) drop_cnt[i]++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cap_size(input int w);
    case (w)
      0: return cap0.size();
      1: return cap1.size();
      default: return cap2.size();
    endcase
  endfunction

  task automatic get_cap(input int w, input int base);
    got_q.delete();
    for (int k = base; k < cap_size(w); k++) begin
      case (w)
        0: got_q.push_back(cap0[k]);
        1: got_q.push_back(cap1[k]);
        default: got_q.push_back(cap2[k]);
      endcase
    end
  endtask

  // Reference frame: decimal digits of min(value, 10^digits-1), MS first
  task automatic build_exp(input int digits, input int v0, input int v1, input logic [1:0] vv);
    int v, lim, p;
    exp_q.delete();
    lim = 10 ** digits - 1;
    for (int c = 0; c < 2; c++) begin
      v = (c == 0) ? v0 : v1;
      if (c > 0) exp_q.push_back(8'h2C);
      if (!vv[c]) begin
        for (int k = 0; k < digits; k++) exp_q.push_back(8'h2D);
      end else begin
        if (v > lim) v = lim;
        p = 10 ** (digits - 1);
        for (int k = 0; k < digits; k++) begin
          exp_q.push_back(8'(8'h30 + (v / p) % 10));
          p = p / 10;
        end
      end
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic cmp_frame(input string tag, input int w, input int base);
    get_cap(w, base);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_b%0d", tag, k), got_q[k], exp_q[k]);
  endtask

  // Waits, with a cycle budget, until frame_done is seen.
  task automatic wait_done(input string tag, input int w, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (w < 2) dat[w] = 16'($urandom);
      if (fd[w]) break;
    end
    check({tag, "_done_seen"}, fd[w], 1'b1);
    check({tag, "_busy_low_at_done"}, fb[w], 1'b0);
  endtask

  // Called on a falling edge. Drives one frame request and checks the frame.
  task automatic run_frame(input string tag, input int w, input int digits, input int v0,
                           input int v1, input logic [1:0] vv, input bit drop, input bit stl);
    int base, d0, r0, s0;
    base = cap_size(w);
    d0 = done_cnt[w];
    r0 = drop_cnt[w];
    blen[w] = 3'($urandom_range(1, 4));
    dat[w] = {8'(v1), 8'(v0)};
    vld[w] = vv;
    req[w] = 1'b1;
    @(negedge clk);
    req[w] = 1'b0;
    dat[w] = 16'($urandom);
    check({tag, "_busy_rise"}, fb[w], 1'b1);
    repeat (2) begin
      @(negedge clk);
      dat[w] = 16'($urandom);
    end
    @(negedge clk);
    if (drop) req[w] = 1'b1;
    @(negedge clk);
    req[w] = 1'b0;
    if (stl) begin
      for (int n = 0; n < 500 && cap_size(w) < base + 3; n++) @(negedge clk);
      check({tag, "_pre_stall_bytes"}, cap_size(w) - base, 3);
      stall[w] = 1'b1;
      s0 = start_cnt[w];
      repeat (1000) @(negedge clk);
      check({tag, "_stall_starts"}, start_cnt[w] - s0, 0);
      check({tag, "_stall_bytes"}, cap_size(w) - base, 3);
      stall[w] = 1'b0;
    end
    wait_done(tag, w, 3000);
    build_exp(digits, v0, v1, vv);
    repeat (20) @(negedge clk);
    cmp_frame(tag, w, base);
    check({tag, "_done_count"}, done_cnt[w] - d0, 1);
    check({tag, "_drop_count"}, drop_cnt[w] - r0, drop ? 1 : 0);
  endtask

  initial begin
    int base, n;
    logic prev;
    req = '0;
    stall = '0;
    blen = {3'd2, 3'd2, 3'd2};
    dat = '0;
    vld = '0;
    dat[2] = {8'd45, 8'd123};
    vld[2] = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_tx_start", st[0], 1'b0);
    check("rst_tx_data", td[0], 8'h00);
    check("rst_frame_busy", fb[0], 1'b0);
    check("rst_frame_done", fd[0], 1'b0);
    check("rst_req_dropped", dr[0], 1'b0);
    rst_n = 1'b1;

    // Frame requested in the first cycle after reset, plus a dropped retrigger
    run_frame("f25_60", 0, 3, 25, 60, 2'b11, 1'b1, 1'b0);
    run_frame("stall", 0, 3, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              2'b11, 1'b0, 1'b1);
    run_frame("ch0_invalid", 0, 3, int'($urandom_range(0, 255)), 100, 2'b10, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++)
      run_frame($sformatf("rand_a%0d", r), 0, 3, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 2'($urandom), 1'b0, 1'b0);

    run_frame("sat255_7", 1, 2, 255, 7, 2'b11, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      run_frame($sformatf("rand_b%0d", r), 1, 2, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 2'($urandom), 1'b0, 1'b0);

    // Auto-triggered instance: reset in the middle of a frame
    prev = fb[2];
    for (n = 0; n < 12000; n++) begin
      @(negedge clk);
      if (fb[2] && !prev) break;
      prev = fb[2];
    end
    check("auto_frame_start", fb[2], 1'b1);
    base = cap_size(2);
    for (n = 0; n < 2000 && cap_size(2) < base + 4; n++) @(negedge clk);
    check("auto_four_bytes", cap_size(2) - base, 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", st[2], 1'b0);
    check("mid_rst_frame_busy", fb[2], 1'b0);
    check("mid_rst_tx_data", td[2], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    base = cap_size(2);
    n = 0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (fb[2]) break;
    end
    check("auto_restart_cycles", n, 5000);
    check("no_bytes_after_reset", cap_size(2) - base, 0);
    wait_done("auto_frame", 2, 3000);
    repeat (5) @(negedge clk);
    build_exp(3, 123, 45, 2'b11);
    cmp_frame("auto_frame", 2, base);

    check("proto_a", viol_cnt[0], 0);
    check("proto_b", viol_cnt[1], 0);
    check("proto_c", viol_cnt[2], 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
